// File: rtl/stg_mem_resp_pkg.sv
// Shared types and default sizes for the ping-pong memory responder.
// The FSM encoding lives here so the top and any later tooling agree on it.
package stg_mem_resp_pkg;

  localparam int MR_DATA_W     = 24;
  localparam int MR_ADDR_W     = 24;
  localparam int MR_DEPTH_LOG2 = 12;

  typedef enum logic [1:0] {
    MR_IDLE        = 2'd0,
    MR_WIDE2       = 2'd1,
    MR_FAULT_DRAIN = 2'd2
  } mr_state_e;

endpackage

// File: rtl/stg_mem_resp_bank.sv
// Single-port synchronous RAM, one-cycle read latency.
// A read and a write to the same word in one cycle returns the old contents.
module mem_bank_sp #(
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [1 << DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset, so they map onto block RAM;
  // consumers must qualify rdata_o with their own registered valid.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stg_mem_resp.sv
// Responder end of the ping-pong address interface: captures the address on port ~mp,
// executes the narrow/wide access on port mp one cycle later, and watches mp toggling.
module stg_mem_resp
  import stg_mem_resp_pkg::*;
#(
  parameter int DATA_W     = MR_DATA_W,
  parameter int ADDR_W     = MR_ADDR_W,
  parameter int DEPTH_LOG2 = MR_DEPTH_LOG2
) (
  input  logic                iw_clk,
  input  logic                iw_rst_n,
  input  logic                iw_mem_mp,
  input  logic [ADDR_W-1:0]   iw_mem_addr0,
  input  logic [ADDR_W-1:0]   iw_mem_addr1,
  input  logic                iw_re,
  input  logic                iw_we,
  input  logic                iw_wide,
  input  logic [2*DATA_W-1:0] iw_wdata,
  output logic [2*DATA_W-1:0] ow_rdata,
  output logic                ow_rvalid,
  output logic                ow_stall,
  output logic                ow_fault,
  output logic                ow_mp_err
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(1) << DEPTH_LOG2;

  mr_state_e             state_q;
  logic [ADDR_W-1:0]     r_addr_q [2];
  logic                  r_mp_exp_q;
  logic                  mp_err_q;
  logic                  rvalid_q;
  logic                  rd_wide_q;
  logic                  wide_wr_q;
  logic [DEPTH_LOG2-1:0] hi_addr_q;
  logic [DATA_W-1:0]     hi_wdata_q;
  logic [DATA_W-1:0]     lo_q;

  logic [ADDR_W-1:0]     acc_addr;
  logic [ADDR_W:0]       acc_addr_p1;
  logic [ADDR_W-1:0]     cap_addr;
  logic                  req;
  logic                  fault_hit;
  logic                  wide_go;
  logic                  narrow_go;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  always_comb begin
    acc_addr    = r_addr_q[iw_mem_mp];
    acc_addr_p1 = {1'b0, acc_addr} + (ADDR_W + 1)'(1);
    cap_addr    = iw_mem_mp ? iw_mem_addr0 : iw_mem_addr1;
    // Gating with reset keeps stall low and blocks any write while reset is held.
    req         = iw_rst_n && (state_q == MR_IDLE) && (iw_re || iw_we);
    fault_hit   = req && (({1'b0, acc_addr} >= DEPTH_X) || (iw_wide && (acc_addr_p1 >= DEPTH_X)));
    wide_go     = req && iw_wide && !fault_hit;
    narrow_go   = req && !iw_wide && !fault_hit;

    ram_addr  = acc_addr[DEPTH_LOG2-1:0];
    ram_wdata = iw_wdata[DATA_W-1:0];
    ram_we    = (narrow_go || wide_go) && iw_we;
    if (state_q == MR_WIDE2) begin
      ram_addr  = hi_addr_q;
      ram_wdata = hi_wdata_q;
      ram_we    = wide_wr_q && iw_rst_n;
    end
  end

  mem_bank_sp #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bank (
    .clk_i   (iw_clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q     <= MR_IDLE;
      r_addr_q[0] <= '0;
      r_addr_q[1] <= '0;
      r_mp_exp_q  <= 1'b0;
      mp_err_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rd_wide_q   <= 1'b0;
      wide_wr_q   <= 1'b0;
      hi_addr_q   <= '0;
      hi_wdata_q  <= '0;
      lo_q        <= '0;
    end else begin
      // Upstream is frozen while stalled and re-presents the same address afterwards.
      if (!wide_go) begin
        r_addr_q[~iw_mem_mp] <= cap_addr;
        r_mp_exp_q           <= ~r_mp_exp_q;
      end
      if (iw_mem_mp != r_mp_exp_q) begin
        mp_err_q <= 1'b1;
      end
      rvalid_q  <= 1'b0;
      rd_wide_q <= 1'b0;
      case (state_q)
        MR_IDLE: begin
          if (fault_hit) begin
            state_q <= MR_FAULT_DRAIN;
          end else if (wide_go) begin
            state_q    <= MR_WIDE2;
            hi_addr_q  <= acc_addr_p1[DEPTH_LOG2-1:0];
            hi_wdata_q <= iw_wdata[2*DATA_W-1:DATA_W];
            wide_wr_q  <= iw_we;
          end else if (narrow_go && !iw_we) begin
            rvalid_q <= 1'b1;
          end
        end
        MR_WIDE2: begin
          lo_q      <= ram_rdata;
          rvalid_q  <= !wide_wr_q;
          rd_wide_q <= 1'b1;
          state_q   <= MR_IDLE;
        end
        MR_FAULT_DRAIN: state_q <= MR_IDLE;
        default:        state_q <= MR_IDLE;
      endcase
    end
  end

  assign ow_stall  = wide_go;
  assign ow_fault  = (state_q == MR_FAULT_DRAIN);
  assign ow_rvalid = rvalid_q;
  assign ow_mp_err = mp_err_q;
  assign ow_rdata  = !rvalid_q ? '0 :
                     rd_wide_q ? {ram_rdata, lo_q} : {{DATA_W{1'b0}}, ram_rdata};

endmodule
